// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle: pixel enable, coordinates, sync/blank and frame status
// driven by the timing generator and consumed by the renderer and video DAC.
`timescale 1ns/1ps

interface vga_timing_gen_if #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned FRAME_W = 16
);

  logic               pix_tick;
  logic               vga_clk;
  logic [COORD_W-1:0] pixelx;
  logic [COORD_W-1:0] pixely;
  logic               active;
  logic               line_start;
  logic               frame_start;
  logic               hsync;
  logic               vsync;
  logic               blank;
  logic               sync;
  logic [FRAME_W-1:0] frame_count;

  // Timing generator side
  modport master (
    output pix_tick, vga_clk, pixelx, pixely, active, line_start, frame_start,
           hsync, vsync, blank, sync, frame_count
  );

  // Renderer / DAC side
  modport slave (
    input pix_tick, vga_clk, pixelx, pixely, active, line_start, frame_start,
          hsync, vsync, blank, sync, frame_count
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: clock divider, pixel/line counters,
// sync/blank generation and a pixel-tick delay line that matches the
// renderer's colour latency.
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned PIPE     = 1,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);

  // Configuration sanity terms, evaluated at elaboration
  localparam bit CFG_DIV_OK   = (CLK_DIV >= 2) && ((CLK_DIV % 2) == 0);
  localparam bit CFG_PIPE_OK  = (PIPE <= 4);
  localparam bit CFG_H_FIT_OK = (64'(H_TOTAL) <= (64'(1) << COORD_W));
  localparam bit CFG_V_FIT_OK = (64'(V_TOTAL) <= (64'(1) << COORD_W));
  localparam bit CFG_DIM_OK   = (H_ACTIVE > 0) && (V_ACTIVE > 0);

  // Position (0,0) is visible whenever both active regions are non-empty
  localparam bit ORIGIN_ACTIVE = (H_ACTIVE > 0) && (V_ACTIVE > 0);

  // Divider state
  logic [DIV_W-1:0]   div_cnt;
  logic               pix_tick_q;
  logic               vga_clk_q;

  // Raster state
  logic [COORD_W-1:0] pixelx_q;
  logic [COORD_W-1:0] pixely_q;
  logic               active_q;
  logic               line_start_q;
  logic               frame_start_q;
  logic [FRAME_W-1:0] frame_count_q;

  // Delay line, stage 0 holds the value for the pixel now on the counters
  logic [PIPE:0]      hs_dly;
  logic [PIPE:0]      vs_dly;
  logic [PIPE:0]      bl_dly;

  // Next-state terms
  logic               tick_c;
  logic [DIV_W-1:0]   div_nxt_c;
  logic               x_wrap_c;
  logic               y_wrap_c;
  logic [COORD_W-1:0] x_nxt_c;
  logic [COORD_W-1:0] y_nxt_c;
  logic               hs_raw_c;
  logic               vs_raw_c;
  logic               act_raw_c;

  // Half-open window test done at 32 bits so window ends equal to the
  // total never alias inside a narrow coordinate width
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

  // Divider, counter and raw sync/blank next-state evaluation
  always_comb begin
    tick_c    = (div_cnt == DIV_LAST);
    div_nxt_c = tick_c ? '0 : div_cnt + DIV_W'(1);

    x_wrap_c  = (pixelx_q == X_LAST);
    y_wrap_c  = (pixely_q == Y_LAST);
    x_nxt_c   = x_wrap_c ? '0 : pixelx_q + COORD_W'(1);
    y_nxt_c   = pixely_q;
    if (x_wrap_c) begin
      y_nxt_c = y_wrap_c ? '0 : pixely_q + COORD_W'(1);
    end

    // Raw values belong to the pixel the counters are about to show
    hs_raw_c  = in_window(x_nxt_c, HS_START, HS_END) ? HS_POL : ~HS_POL;
    vs_raw_c  = in_window(y_nxt_c, VS_START, VS_END) ? VS_POL : ~VS_POL;
    act_raw_c = in_window(x_nxt_c, 0, H_ACTIVE) && in_window(y_nxt_c, 0, V_ACTIVE);
  end

  // Clock divider: pixel enable and 50% duty DAC clock
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      pix_tick_q <= 1'b0;
      vga_clk_q  <= 1'b0;
    end else begin
      div_cnt    <= div_nxt_c;
      pix_tick_q <= tick_c;
      vga_clk_q  <= (div_nxt_c >= DIV_HALF);
    end
  end

  // Raster counters, wrap pulses and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pixelx_q      <= '0;
      pixely_q      <= '0;
      active_q      <= ORIGIN_ACTIVE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      line_start_q  <= tick_c && x_wrap_c;
      frame_start_q <= tick_c && x_wrap_c && y_wrap_c;
      if (tick_c) begin
        pixelx_q <= x_nxt_c;
        pixely_q <= y_nxt_c;
        active_q <= act_raw_c;
        if (x_wrap_c && y_wrap_c) begin
          frame_count_q <= frame_count_q + FRAME_W'(1);
        end
      end
    end
  end

  // Sync/blank delay line, advanced once per pixel so latency is in ticks
  generate
    if (PIPE == 0) begin : g_no_dly
      // Zero added latency: one register aligned with the counters
      always_ff @(posedge clk) begin
        if (rst) begin
          hs_dly <= ~HS_POL;
          vs_dly <= ~VS_POL;
          bl_dly <= 1'b0;
        end else if (tick_c) begin
          hs_dly <= hs_raw_c;
          vs_dly <= vs_raw_c;
          bl_dly <= act_raw_c;
        end
      end
    end else begin : g_dly
      // Shift register; reset fills every stage with idle values
      always_ff @(posedge clk) begin
        if (rst) begin
          hs_dly <= {(PIPE+1){~HS_POL}};
          vs_dly <= {(PIPE+1){~VS_POL}};
          bl_dly <= '0;
        end else if (tick_c) begin
          hs_dly <= {hs_dly[PIPE-1:0], hs_raw_c};
          vs_dly <= {vs_dly[PIPE-1:0], vs_raw_c};
          bl_dly <= {bl_dly[PIPE-1:0], act_raw_c};
        end
      end
    end
  endgenerate

  // Configuration and counter range checks for simulation
  always_ff @(posedge clk) begin : p_checks
    if (!rst) begin
      assert (CFG_DIV_OK)
        else $error("vga_timing_gen: CLK_DIV must be even and >= 2");
      assert (CFG_PIPE_OK)
        else $error("vga_timing_gen: PIPE must be in 0..4");
      assert (CFG_H_FIT_OK && CFG_V_FIT_OK)
        else $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
      assert (CFG_DIM_OK)
        else $error("vga_timing_gen: active region must be non-empty");
      assert (32'(pixelx_q) < H_TOTAL)
        else $error("vga_timing_gen: pixelx overflow");
      assert (32'(pixely_q) < V_TOTAL)
        else $error("vga_timing_gen: pixely overflow");
      assert (!frame_start_q || line_start_q)
        else $error("vga_timing_gen: frame_start without line_start");
    end
  end

  // Output mapping; every signal except the constant sync is a flop
  assign vga.pix_tick    = pix_tick_q;
  assign vga.vga_clk     = vga_clk_q;
  assign vga.pixelx      = pixelx_q;
  assign vga.pixely      = pixely_q;
  assign vga.active      = active_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;
  assign vga.hsync       = hs_dly[PIPE];
  assign vga.vsync       = vs_dly[PIPE];
  assign vga.blank       = bl_dly[PIPE];
  assign vga.sync        = 1'b1;

endmodule
